// File: rtl/pb_cmd_arbiter_if.sv
// Command-stream bundle between the push-button arbiter (master) and its consumer (slave).
// Carries the raw button pins plus the valid/ready command channel and the overrun flag.
interface pb_cmd_arbiter_if #(
  parameter int NUM_PB = 4
) ();
  localparam int IDW = $clog2(NUM_PB);

  logic [NUM_PB-1:0] PB;
  logic              cmd_rdy;
  logic              cmd_vld;
  logic [IDW-1:0]    cmd_id;
  logic              cmd_long;
  logic              overrun;

  modport master (
    input  PB,
    input  cmd_rdy,
    output cmd_vld,
    output cmd_id,
    output cmd_long,
    output overrun
  );

  modport slave (
    output PB,
    output cmd_rdy,
    input  cmd_vld,
    input  cmd_id,
    input  cmd_long,
    input  overrun
  );
endinterface

// File: rtl/pb_cmd_arbiter.sv
// Push-button front end: sync + debounce per button, short/long release classification,
// one pending event per button, round-robin arbitration onto a valid/ready command stream.
module pb_cmd_arbiter #(
  parameter int NUM_PB       = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_CYC     = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  pb_cmd_arbiter_if.master   cmd_if
);
  localparam int IDW = $clog2(NUM_PB);
  localparam int IW1 = IDW + 1;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PCW = $clog2(LONG_CYC + 1);
  localparam logic [DBW-1:0] DBC_MAX = DBW'(DEBOUNCE_CYC);
  localparam logic [PCW-1:0] PC_MAX  = PCW'(LONG_CYC);
  localparam logic [IW1-1:0] NUM_W   = IW1'(NUM_PB);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_PB - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  logic [NUM_PB-1:0]          sync1_q, sync2_q;
  logic [NUM_PB-1:0]          db_q, db_d;
  logic [NUM_PB-1:0][DBW-1:0] dbc_q, dbc_d;
  logic [NUM_PB-1:0][PCW-1:0] press_cnt_q, press_cnt_d;
  logic [NUM_PB-1:0]          rel_q, rise_s;
  logic [NUM_PB-1:0]          pending_q, pending_d;
  logic [NUM_PB-1:0]          plong_q, plong_d;
  logic [NUM_PB-1:0]          keep_s, ovr_s, grant_s;
  state_e                     state_q, state_d;
  logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
  logic                       cmd_vld_q, cmd_vld_d;
  logic [IDW-1:0]             cmd_id_q, cmd_id_d;
  logic                       cmd_long_q, cmd_long_d;
  logic                       overrun_q, overrun_d;
  logic                       found_s;
  logic [IDW-1:0]             sel_s;
  logic [IW1-1:0]             idx_s;

  // Debounce: a level change is accepted only after it has persisted through the full
  // mismatch count; the press timer restarts on every accepted press.
  always_comb begin
    db_d        = db_q;
    dbc_d       = dbc_q;
    press_cnt_d = press_cnt_q;
    rise_s      = '0;
    for (int i = 0; i < NUM_PB; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DBC_MAX) begin
          db_d[i]  = sync2_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DBW'(1'b1);
        end
      end else begin
        dbc_d[i] = '0;
      end
      if (db_q[i] && !db_d[i]) begin
        press_cnt_d[i] = '0;
      end else if (!db_q[i] && (press_cnt_q[i] != PC_MAX)) begin
        press_cnt_d[i] = press_cnt_q[i] + PCW'(1'b1);
      end else begin
        press_cnt_d[i] = press_cnt_q[i];
      end
      rise_s[i] = !db_q[i] && db_d[i];
    end
  end

  // Event capture: a grant in the same cycle frees the slot, so a new release is stored.
  always_comb begin
    keep_s    = pending_q & ~grant_s;
    ovr_s     = rel_q & keep_s;
    pending_d = keep_s | rel_q;
    plong_d   = plong_q;
    for (int i = 0; i < NUM_PB; i++) begin
      if (rel_q[i] && !keep_s[i]) begin
        plong_d[i] = (press_cnt_q[i] >= PC_MAX);
      end else begin
        plong_d[i] = plong_q[i];
      end
    end
    overrun_d = |ovr_s;
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_PB; k++) begin
      idx_s = {1'b0, rr_ptr_q} + IW1'(k);
      if (idx_s >= NUM_W) begin
        idx_s = idx_s - NUM_W;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && pending_q[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        sel_s   = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbiter FSM next state and command outputs.
  always_comb begin
    state_d    = state_q;
    cmd_vld_d  = cmd_vld_q;
    cmd_id_d   = cmd_id_q;
    cmd_long_d = cmd_long_q;
    rr_ptr_d   = rr_ptr_q;
    grant_s    = '0;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_s[sel_s] = 1'b1;
          cmd_id_d       = sel_s;
          cmd_long_d     = plong_q[sel_s];
          cmd_vld_d      = 1'b1;
          state_d        = ST_OFFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (cmd_if.cmd_rdy) begin
          cmd_vld_d = 1'b0;
          state_d   = ST_IDLE;
          if (cmd_id_q == LAST_ID) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = cmd_id_q + IDW'(1'b1);
          end
        end else begin
          state_d = ST_OFFER;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cmd_vld_d = 1'b0;
      end
    endcase
  end

  // State registers; sync and debounced levels idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      db_q        <= '1;
      dbc_q       <= '0;
      press_cnt_q <= '0;
      rel_q       <= '0;
      pending_q   <= '0;
      plong_q     <= '0;
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_id_q    <= '0;
      cmd_long_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= cmd_if.PB;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      dbc_q       <= dbc_d;
      press_cnt_q <= press_cnt_d;
      rel_q       <= rise_s;
      pending_q   <= pending_d;
      plong_q     <= plong_d;
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_id_q    <= cmd_id_d;
      cmd_long_q  <= cmd_long_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_if.cmd_vld  = cmd_vld_q;
  assign cmd_if.cmd_id   = cmd_id_q;
  assign cmd_if.cmd_long = cmd_long_q;
  assign cmd_if.overrun  = overrun_q;
endmodule

// File: tb/tb_pb_cmd_arbiter.sv
// Directed bench for pb_cmd_arbiter: expected commands are queued at release time and
// matched against each handshake; overrun pulses and offer stability are tracked alongside.
module tb_pb_cmd_arbiter;
  localparam int NUM_PB = 4;

  typedef struct packed {
    logic [1:0] id;
    logic       lng;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   hs_cnt;
  int   ovr_cnt;
  int   hs0;
  int   ovr0;
  exp_t sb[$];
  exp_t e;
  logic hold_q;
  logic gap_q;
  logic [1:0] prev_id;
  logic prev_long;

  pb_cmd_arbiter_if #(.NUM_PB(NUM_PB)) bus ();

  pb_cmd_arbiter #(
    .NUM_PB(NUM_PB),
    .DEBOUNCE_CYC(4),
    .LONG_CYC(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int idx, input int low_cyc);
    bus.PB[idx] = 1'b0;
    ticks(low_cyc);
    bus.PB[idx] = 1'b1;
  endtask

  task automatic push(input logic [1:0] id, input logic lng);
    exp_t x;
    x.id  = id;
    x.lng = lng;
    sb.push_back(x);
  endtask

  // Monitor: scoreboard pop on handshake, offer stability, mandatory idle gap, overrun count.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_q = 1'b0;
      gap_q  = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_vld", 32'(bus.cmd_vld), 32'd1);
        check("hold_id", 32'(bus.cmd_id), 32'(prev_id));
        check("hold_long", 32'(bus.cmd_long), 32'(prev_long));
      end
      if (gap_q) check("idle_gap", 32'(bus.cmd_vld), 32'd0);
      if (bus.overrun) ovr_cnt++;
      if (bus.cmd_vld && bus.cmd_rdy) begin
        hs_cnt++;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("cmd_id", 32'(bus.cmd_id), 32'(e.id));
          check("cmd_long", 32'(bus.cmd_long), 32'(e.lng));
        end
      end
      hold_q    = bus.cmd_vld && !bus.cmd_rdy;
      gap_q     = bus.cmd_vld && bus.cmd_rdy;
      prev_id   = bus.cmd_id;
      prev_long = bus.cmd_long;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; hs_cnt = 0; ovr_cnt = 0;
    hold_q = 1'b0; gap_q = 1'b0; prev_id = 2'd0; prev_long = 1'b0;
    rst_n = 1'b0;
    bus.PB = 4'hF;
    bus.cmd_rdy = 1'b1;
    ticks(3);
    check("rst_vld", 32'(bus.cmd_vld), 32'd0);
    check("rst_id", 32'(bus.cmd_id), 32'd0);
    check("rst_long", 32'(bus.cmd_long), 32'd0);
    check("rst_ovr", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Long press on PB[1] with release-to-valid latency.
    hs0 = hs_cnt;
    push(2'd1, 1'b1);
    press(1, 20);
    ticks(8);
    check("t1_lat_early", 32'(bus.cmd_vld), 32'd0);
    tick();
    check("t1_lat", 32'(bus.cmd_vld), 32'd1);
    ticks(20);
    check("t1_hs", 32'(hs_cnt - hs0), 32'd1);

    // Glitch on PB[3] is filtered.
    hs0 = hs_cnt; ovr0 = ovr_cnt;
    press(3, 3);
    ticks(30);
    check("t2_hs", 32'(hs_cnt - hs0), 32'd0);
    check("t2_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    check("t2_vld", 32'(bus.cmd_vld), 32'd0);

    // Short press on PB[1].
    hs0 = hs_cnt;
    push(2'd1, 1'b0);
    press(1, 6);
    ticks(25);
    check("t3_hs", 32'(hs_cnt - hs0), 32'd1);
    check("t3_sb", 32'(sb.size()), 32'd0);

    // Simultaneous releases from a fresh rr_ptr.
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    hs0 = hs_cnt;
    push(2'd0, 1'b0);
    push(2'd2, 1'b0);
    bus.PB = 4'b1010;
    ticks(8);
    bus.PB = 4'hF;
    ticks(25);
    check("t4a_hs", 32'(hs_cnt - hs0), 32'd2);
    check("t4a_sb", 32'(sb.size()), 32'd0);
    hs0 = hs_cnt;
    push(2'd3, 1'b0);
    push(2'd0, 1'b0);
    bus.PB = 4'b0110;
    ticks(8);
    bus.PB = 4'hF;
    ticks(25);
    check("t4b_hs", 32'(hs_cnt - hs0), 32'd2);
    check("t4b_sb", 32'(sb.size()), 32'd0);

    // Stalled consumer: offer held, second release queued, third release overruns.
    bus.cmd_rdy = 1'b0;
    hs0 = hs_cnt; ovr0 = ovr_cnt;
    push(2'd2, 1'b1);
    press(2, 40);
    ticks(20);
    check("t5_vld", 32'(bus.cmd_vld), 32'd1);
    check("t5_id", 32'(bus.cmd_id), 32'd2);
    push(2'd2, 1'b1);
    press(2, 40);
    ticks(20);
    check("t5_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
    press(2, 40);
    ticks(20);
    check("t5_ovr", 32'(ovr_cnt - ovr0), 32'd1);
    check("t5_long", 32'(bus.cmd_long), 32'd1);
    bus.cmd_rdy = 1'b1;
    ticks(20);
    check("t5_hs", 32'(hs_cnt - hs0), 32'd2);
    check("t5_sb", 32'(sb.size()), 32'd0);

    // Reset while offering with PB[1] pending.
    bus.cmd_rdy = 1'b0;
    hs0 = hs_cnt;
    push(2'd1, 1'b0);
    press(1, 8);
    ticks(20);
    push(2'd1, 1'b0);
    press(1, 8);
    ticks(20);
    check("t6_vld_pre", 32'(bus.cmd_vld), 32'd1);
    check("t6_id_pre", 32'(bus.cmd_id), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_vld_rst", 32'(bus.cmd_vld), 32'd0);
    check("t6_id_rst", 32'(bus.cmd_id), 32'd0);
    sb.delete();
    ticks(2);
    rst_n = 1'b1;
    bus.cmd_rdy = 1'b1;
    ticks(40);
    check("t6_hs", 32'(hs_cnt - hs0), 32'd0);
    check("t6_vld_post", 32'(bus.cmd_vld), 32'd0);
    check("final_sb", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
